conv55_seq_ctrl: RTL and testbench
==================================

CONV55_SEQ_CTRL -- requirements
Module: conv55_seq_ctrl

Interface
REQ-001 SHALL have parameter N_TAPS, default 25, meaning taps per 5x5 window.
REQ-002 SHALL have parameter DW, default 6, meaning pixel and coefficient width, unsigned.
REQ-003 SHALL have parameter OW, default 18, meaning result width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state is rising-edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port cfg_we, input, 1, coefficient write strobe.
REQ-007 SHALL have port cfg_addr, input, 5, coefficient index 0..24.
REQ-008 SHALL have port cfg_data, input, DW, coefficient value.
REQ-009 SHALL have port start, input, 1, request to convolve one window.
REQ-010 SHALL have port start_ready, output, 1, high only in IDLE.
REQ-011 SHALL have port pix_valid, input, 1, pixel stream valid.
REQ-012 SHALL have port pix_data, input, DW, window pixel, raster order tap 0..24.
REQ-013 SHALL have port pix_ready, output, 1, high only in ACCUM.
REQ-014 SHALL have port out_valid, output, 1, result valid.
REQ-015 SHALL have port out_data, input-side consumer ready is out_ready; out_data is output, OW, convolution sum.
REQ-016 SHALL have port out_ready, input, 1, result consumer ready.
REQ-017 SHALL have port busy, output, 1, high in ACCUM or HOLD.

Function
REQ-018 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-019 IDLE: start_ready=1; start=1 -> ACCUM next cycle, acc:=0, tap:=0.
REQ-020 ACCUM: pix_ready=1; each pix_valid&pix_ready cycle SHALL add pix_data*coef[tap] to acc and increment tap; pix_valid=0 cycles SHALL hold acc and tap.
REQ-021 On acceptance of tap 24 SHALL latch acc+product into out_data and enter HOLD next cycle (out_valid one cycle after the 25th pixel handshake; 26 cycles minimum start-to-out_valid).
REQ-022 HOLD: out_valid=1, out_data stable until out_valid&out_ready; then IDLE next cycle; no result drop under backpressure.
REQ-023 Arithmetic: unsigned DW x DW product, 17-bit accumulate (max 25*63*63=99225, no overflow), zero-extended to OW.
REQ-024 Coefficient writes SHALL be accepted only in IDLE with cfg_addr<N_TAPS; writes when busy or cfg_addr>=25 SHALL be ignored.
REQ-025 cfg_we and start in the same IDLE cycle: write SHALL commit and the new coefficient SHALL be used for that window.
REQ-026 start outside IDLE SHALL be ignored (not queued).
REQ-027 out_data SHALL retain last result after leaving HOLD until the next tap-24 acceptance.

Reset
REQ-028 rst SHALL asynchronously force IDLE, acc=0, tap=0, out_data=0, out_valid=0, pix_ready=0, busy=0, start_ready=1 after release, all coefficients=0.
REQ-029 rst mid-ACCUM or mid-HOLD SHALL abandon the window; no out_valid pulse follows.

Structure
REQ-030 Package conv55_pkg SHALL hold N_TAPS, DW, OW, ACC_W=17 and the FSM state enum.
REQ-031 One sub-module conv55_mac_lane SHALL contain the DW x DW multiplier and accumulator with clear and enable.
REQ-032 Coefficients SHALL be a 25-entry register array indexed by tap, no RAM macro.

Verification
REQ-033 Coefs all 1, pixels 0..24 back-to-back -> out_data=300, out_valid at cycle 26 after start.
REQ-034 Coefs all 63, pixels all 63 -> out_data=99225, no wrap.
REQ-035 pix_valid toggling 1/0 every cycle, coef[i]=i, pixels=1 -> out_data=300 after 50 pixel cycles.
REQ-036 out_ready held 0 for 10 cycles in HOLD -> out_valid and out_data stable, start ignored, then IDLE one cycle after handshake.
REQ-037 rst asserted after tap 12 -> all outputs reset values, coefs 0; next window with pixels 5 -> out_data=0.
REQ-038 cfg_we during ACCUM and cfg_addr=25 in IDLE -> coefficient array unchanged, results unaffected.

Source files
------------

// File: rtl/conv55_pkg.sv
// Shared constants and FSM state encoding for the 5x5 convolution sequencer.
package conv55_pkg;

  // Taps per 5x5 window.
  localparam int N_TAPS = 25;
  // Pixel and coefficient width (unsigned).
  localparam int DW     = 6;
  // Result width presented on out_data.
  localparam int OW     = 18;
  // Accumulator width: 25 * 63 * 63 = 99225 fits in 17 bits.
  localparam int ACC_W  = 17;
  // Width of a tap index / coefficient address (0..24).
  localparam int TAP_W  = 5;

  // Sequencer states: wait for start, accumulate the window, present the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage : conv55_pkg

// File: rtl/conv55_mac_lane.sv
// Single multiply-accumulate lane: unsigned DW x DW product summed into an
// ACC_W accumulator, with synchronous clear and enable.
module conv55_mac_lane #(
  parameter int DW    = conv55_pkg::DW,
  parameter int ACC_W = conv55_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [DW-1:0]    pix_i,
  input  logic [DW-1:0]    coef_i,
  output logic [ACC_W-1:0] acc_o,
  output logic [ACC_W-1:0] sum_o
);
  import conv55_pkg::*;

  logic [2*DW-1:0]  prod;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] sum;

  // Operands are zero-extended so the product is computed at full width.
  assign prod  = {{DW{1'b0}}, pix_i} * {{DW{1'b0}}, coef_i};
  // sum is exposed so the sequencer can capture the final tap without an
  // extra cycle of latency.
  assign sum   = acc_q + ACC_W'(prod);
  assign acc_o = acc_q;
  assign sum_o = sum;

  // Accumulator register: clear at window start, add one product per accepted pixel.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples the pre-edge values, independent of block ordering.
    if (rst) begin
      acc_q <= '0;
    end else if (clear_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= sum;
    end
  end

endmodule : conv55_mac_lane

// File: rtl/conv55_seq_ctrl.sv
// 5x5 convolution window sequencer: holds the 25 coefficients, accepts one
// window of pixels in raster order, accumulates pix*coef and presents the sum
// with a valid/ready handshake that holds the result under backpressure.
module conv55_seq_ctrl #(
  parameter int N_TAPS = conv55_pkg::N_TAPS,
  parameter int DW     = conv55_pkg::DW,
  parameter int OW     = conv55_pkg::OW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [4:0]    cfg_addr,
  input  logic [DW-1:0] cfg_data,
  input  logic          start,
  output logic          start_ready,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  output logic          pix_ready,
  output logic          out_valid,
  output logic [OW-1:0] out_data,
  input  logic          out_ready,
  output logic          busy
);
  import conv55_pkg::*;

  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(N_TAPS - 1);

  state_e           state_q, state_d;
  logic [TAP_W-1:0] tap_q, tap_d;
  logic [DW-1:0]    coef_q [N_TAPS];
  logic [DW-1:0]    coef_sel;
  logic [OW-1:0]    out_data_q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic             mac_clear;
  logic             mac_en;
  logic             out_load;
  logic             cfg_wr_en;

  // Coefficients are only writable while idle and only for in-range taps, so
  // a window in flight always sees a stable coefficient set.
  assign cfg_wr_en = (state_q == IDLE) && cfg_we && (cfg_addr <= LAST_TAP);
  assign coef_sel  = coef_q[tap_q];

  // Coefficient register array, indexed by tap.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: this array is small flop storage and must read back as zero after
    // reset, so every entry is reset; a RAM-style array would be left unreset.
    if (rst) begin
      for (int i = 0; i < N_TAPS; i++) begin
        coef_q[i] <= '0;
      end
    end else if (cfg_wr_en) begin
      coef_q[cfg_addr] <= cfg_data;
    end
  end

  conv55_mac_lane #(
    .DW    (DW),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst     (rst),
    .clear_i (mac_clear),
    .en_i    (mac_en),
    .pix_i   (pix_data),
    .coef_i  (coef_sel),
    .acc_o   (acc),
    .sum_o   (acc_sum)
  );

  // State and tap-index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
    end
  end

  // Next-state logic: start only in IDLE, count accepted pixels in ACCUM,
  // hold the result until the consumer takes it.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d   = state_q;
    tap_d     = tap_q;
    mac_clear = 1'b0;
    mac_en    = 1'b0;
    out_load  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ACCUM;
          tap_d     = '0;
          mac_clear = 1'b1;
        end
      end
      ACCUM: begin
        if (pix_valid) begin
          mac_en = 1'b1;
          if (tap_q == LAST_TAP) begin
            out_load = 1'b1;
            state_d  = HOLD;
          end else begin
            tap_d = tap_q + 1'b1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Result register: captured on the last tap, retained until the next window ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q <= '0;
    end else if (out_load) begin
      out_data_q <= OW'(acc_sum);
    end
  end

  // Handshake outputs are decoded directly from the registered state.
  assign start_ready = (state_q == IDLE);
  assign pix_ready   = (state_q == ACCUM);
  assign out_valid   = (state_q == HOLD);
  assign busy        = (state_q == ACCUM) || (state_q == HOLD);
  assign out_data    = out_data_q;

endmodule : conv55_seq_ctrl

// File: tb/tb_conv55_seq_ctrl.sv
// Directed self-checking bench for conv55_seq_ctrl with a result scoreboard.
`timescale 1ns/1ps
module tb_conv55_seq_ctrl;

  localparam int NT = 25;
  localparam int DW = 6;
  localparam int OW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [4:0]    cfg_addr;
  logic [DW-1:0] cfg_data;
  logic          start;
  logic          start_ready;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic          out_valid;
  logic [OW-1:0] out_data;
  logic          out_ready;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int coef_m[NT];

  always #5 clk = ~clk;

  conv55_seq_ctrl #(.N_TAPS(NT), .DW(DW), .OW(OW)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .start       (start),
    .start_ready (start_ready),
    .pix_valid   (pix_valid),
    .pix_data    (pix_data),
    .pix_ready   (pix_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input int px[NT]);
    int s = 0;
    for (int i = 0; i < NT; i++) s += px[i] * coef_m[i];
    return s;
  endfunction

  task automatic cfg_write(input int addr, input int data, input bit accept);
    cfg_we   = 1'b1;
    cfg_addr = addr[4:0];
    cfg_data = data[DW-1:0];
    tick();
    cfg_we   = 1'b0;
    if (accept) coef_m[addr] = data;
  endtask

  // Drives one full window; optional coefficient write alongside start,
  // optional idle cycle between pixels, optional illegal writes during ACCUM.
  task automatic run_window(input string tag, input int px[NT], input bit gap,
                            input bit co_we, input int co_addr, input int co_data,
                            input bit cfg_noise, output int cycles);
    int w;
    if (co_we) coef_m[co_addr] = co_data;
    exp_q.push_back(model(px));
    cfg_we   = co_we;
    cfg_addr = co_addr[4:0];
    cfg_data = co_data[DW-1:0];
    start    = 1'b1;
    tick();
    start  = 1'b0;
    cfg_we = 1'b0;
    cycles = 1;
    check({tag, "_pix_ready"}, 32'(pix_ready), 1);
    check({tag, "_busy"}, 32'(busy), 1);
    check({tag, "_start_ready"}, 32'(start_ready), 0);
    for (int i = 0; i < NT; i++) begin
      pix_valid = 1'b1;
      pix_data  = px[i][DW-1:0];
      if (cfg_noise) begin
        cfg_we   = 1'b1;
        cfg_addr = 5'(i);
        cfg_data = 6'd63;
      end
      tick();
      cycles++;
      pix_valid = 1'b0;
      cfg_we    = 1'b0;
      if (gap && i != NT - 1) begin
        tick();
        cycles++;
      end
    end
    w = 0;
    while (out_valid !== 1'b1 && w < 60) begin
      tick();
      w++;
      cycles++;
    end
    check({tag, "_out_valid_seen"}, 32'(out_valid), 1);
  endtask

  // Consumes the held result, optionally stalling and poking start meanwhile.
  task automatic drain(input string tag, input int hold, input bit poke);
    int exp = -1;
    check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 1);
    if (exp_q.size() != 0) exp = exp_q.pop_front();
    out_ready = 1'b0;
    start     = poke;
    for (int k = 0; k < hold; k++) begin
      tick();
      check({tag, "_hold_valid"}, 32'(out_valid), 1);
      check({tag, "_hold_data"}, 32'(out_data), exp);
      check({tag, "_hold_start_ready"}, 32'(start_ready), 0);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check({tag, "_valid"}, 32'(out_valid), 1);
    check({tag, "_data"}, 32'(out_data), exp);
    tick();
    out_ready = 1'b0;
    check({tag, "_post_valid"}, 32'(out_valid), 0);
    check({tag, "_post_start_ready"}, 32'(start_ready), 1);
    check({tag, "_post_busy"}, 32'(busy), 0);
    check({tag, "_retained"}, 32'(out_data), exp);
    if (poke) begin
      tick();
      check({tag, "_not_queued"}, 32'(busy), 0);
    end
  endtask

  initial begin
    int px[NT];
    int cyc;
    int pulses;

    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
    pix_valid = 1'b0; pix_data = '0; out_ready = 1'b0;
    foreach (coef_m[i]) coef_m[i] = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_start_ready", 32'(start_ready), 1);
    check("rst_pix_ready", 32'(pix_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);

    // Coefs all 1, pixels 0..24 back-to-back: 300, valid 26 cycles after start.
    for (int i = 0; i < NT; i++) cfg_write(i, 1, 1'b1);
    for (int i = 0; i < NT; i++) px[i] = i;
    run_window("ones", px, 1'b0, 1'b0, 0, 0, 1'b0, cyc);
    check("ones_latency", 32'(cyc), 26);
    check("ones_expect", 32'(model(px)), 300);
    drain("ones", 0, 1'b0);

    // All 63: full-scale 99225; last coefficient written in the start cycle.
    for (int i = 0; i < NT - 1; i++) cfg_write(i, 63, 1'b1);
    for (int i = 0; i < NT; i++) px[i] = 63;
    run_window("max", px, 1'b0, 1'b1, 24, 63, 1'b0, cyc);
    check("max_expect", 32'(model(px)), 99225);
    drain("max", 0, 1'b0);

    // coef[i]=i, pixels 1, pix_valid toggling: 300 after 50 cycles.
    for (int i = 0; i < NT; i++) cfg_write(i, i, 1'b1);
    for (int i = 0; i < NT; i++) px[i] = 1;
    run_window("gap", px, 1'b1, 1'b0, 0, 0, 1'b0, cyc);
    check("gap_latency", 32'(cyc), 50);
    drain("gap", 0, 1'b0);

    // Backpressure: 10 stalled cycles with start poked in HOLD.
    for (int i = 0; i < NT; i++) px[i] = (i * 7 + 3) % 64;
    run_window("bp", px, 1'b0, 1'b0, 0, 0, 1'b0, cyc);
    drain("bp", 10, 1'b1);

    // Illegal writes: out-of-range address in IDLE, any write during ACCUM.
    cfg_write(25, 50, 1'b0);
    cfg_write(31, 50, 1'b0);
    for (int i = 0; i < NT; i++) px[i] = 63 - 2 * i;
    run_window("ign", px, 1'b0, 1'b0, 0, 0, 1'b1, cyc);
    drain("ign", 0, 1'b0);

    // Reset after tap 12 abandons the window and clears coefficients.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 13; i++) begin
      pix_valid = 1'b1;
      pix_data  = 6'd7;
      tick();
    end
    pix_valid = 1'b0;
    check("mid_busy", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_pix_ready", 32'(pix_ready), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_out_data", 32'(out_data), 0);
    foreach (coef_m[i]) coef_m[i] = 0;
    tick();
    rst = 1'b0;
    tick();
    check("arst_start_ready", 32'(start_ready), 1);
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (out_valid !== 1'b0) pulses++;
    end
    check("arst_no_pulse", 32'(pulses), 0);
    for (int i = 0; i < NT; i++) px[i] = 5;
    run_window("zero", px, 1'b0, 1'b0, 0, 0, 1'b0, cyc);
    drain("zero", 0, 1'b0);
    check("sb_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_conv55_seq_ctrl
